// File: rtl/store_narrow_if.sv
`default_nettype none
// ============================================================================
// Module      : store_narrow_if
// Description : Bus bundle for store_narrow: upstream valid/ready with the
//               store request, downstream valid/ready with the narrowed
//               result, plus the saturating overflow counter.
// Revision    : 1.0  initial release
// ============================================================================
interface store_narrow_if;
  logic        valido_in;
  logic        pronto_out;
  logic [31:0] dado;
  logic [1:0]  endereco;
  logic [1:0]  tamanho;
  logic        controle;
  logic        valido_out;
  logic        pronto_in;
  logic [31:0] saida;
  logic [3:0]  byte_en;
  logic        overflow;
  logic        erro_alinhamento;
  logic [7:0]  cont_overflow;

  // Producer/consumer side (drives requests, accepts results)
  modport master (
    output valido_in, dado, endereco, tamanho, controle, pronto_in,
    input  pronto_out, valido_out, saida, byte_en, overflow,
           erro_alinhamento, cont_overflow
  );

  // Narrowing block side
  modport slave (
    input  valido_in, dado, endereco, tamanho, controle, pronto_in,
    output pronto_out, valido_out, saida, byte_en, overflow,
           erro_alinhamento, cont_overflow
  );
endinterface
`default_nettype wire

// File: rtl/store_narrow.sv
`default_nettype none
// ============================================================================
// Module      : store_narrow
// Description : Narrows a 32-bit store value to byte/half/word, range-checks
//               it (signed or unsigned), places it on its byte lane(s) and
//               buffers up to two results in a FIFO-ordered skid buffer.
//               Optional macro STORE_NARROW_SATURATE_EN clamps out-of-range
//               values instead of truncating them.
// Revision    : 1.0  initial release
// ============================================================================
module store_narrow (
  input  wire logic     clock,
  input  wire logic     reset,
  store_narrow_if.slave bus
);

  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    UM    = 2'd1,
    CHEIO = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] saida;
    logic [3:0]  be;
    logic        ovf;
    logic        err;
  } entry_t;

  localparam logic [7:0] c_CNT_MAX = 8'hFF;

  state_t      r_state, w_state_next;
  entry_t      r_e0, r_e1, w_e0_next, w_e1_next, w_new;
  logic        r_pronto;
  logic [7:0]  r_cont;
  logic        w_accept, w_consume, w_valido;
  logic        w_fits_b, w_fits_h, w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lane;
  logic [4:0]  w_shamt;

  // Range check, narrowing and lane placement of the incoming request
  always_comb begin
    w_fits_b = bus.controle ? ((&bus.dado[31:7])  | ~(|bus.dado[31:7]))
                            : ~(|bus.dado[31:8]);
    w_fits_h = bus.controle ? ((&bus.dado[31:15]) | ~(|bus.dado[31:15]))
                            : ~(|bus.dado[31:16]);
`ifdef STORE_NARROW_SATURATE_EN
    // Signed overflow direction follows the sign of the full value
    w_byte = w_fits_b ? bus.dado[7:0]
           : (bus.controle ? (bus.dado[31] ? 8'h80 : 8'h7F) : 8'hFF);
    w_half = w_fits_h ? bus.dado[15:0]
           : (bus.controle ? (bus.dado[31] ? 16'h8000 : 16'h7FFF) : 16'hFFFF);
`else
    w_byte = bus.dado[7:0];
    w_half = bus.dado[15:0];
`endif
    w_misalign = ((bus.tamanho == 2'b01) && bus.endereco[0])
              || ((bus.tamanho == 2'b10) && (bus.endereco != 2'b00))
              ||  (bus.tamanho == 2'b11);
    w_shamt = {bus.endereco, 3'b000};
    w_lane  = '0;
    w_new   = '0;
    case (bus.tamanho)
      2'b00: begin
        w_lane    = {24'h0, w_byte};
        w_new.be  = 4'b0001 << bus.endereco;
        w_new.ovf = ~w_fits_b;
      end
      2'b01: begin
        w_lane    = {16'h0, w_half};
        w_new.be  = 4'b0011 << bus.endereco;
        w_new.ovf = ~w_fits_h;
      end
      2'b10: begin
        w_lane    = bus.dado;
        w_new.be  = 4'b1111;
        w_new.ovf = 1'b0;
      end
      default: w_lane = '0;
    endcase
    w_new.saida = w_lane << w_shamt;
    // A misaligned request carries only the error flag
    if (w_misalign) begin
      w_new     = '0;
      w_new.err = 1'b1;
    end
  end

  // Handshake decode and skid-buffer next state
  always_comb begin
    w_valido     = (r_state != VAZIO);
    w_accept     = bus.valido_in & r_pronto;
    w_consume    = w_valido & bus.pronto_in;
    w_state_next = r_state;
    w_e0_next    = r_e0;
    w_e1_next    = r_e1;
    case (r_state)
      VAZIO: begin
        if (w_accept) begin
          w_state_next = UM;
          w_e0_next    = w_new;
        end
      end
      UM: begin
        case ({w_accept, w_consume})
          2'b10: begin
            w_state_next = CHEIO;
            w_e1_next    = w_new;
          end
          2'b01: begin
            w_state_next = VAZIO;
            w_e0_next    = '0;
          end
          2'b11: w_e0_next = w_new;
          default: w_state_next = UM;
        endcase
      end
      CHEIO: begin
        if (w_consume) begin
          w_state_next = UM;
          w_e0_next    = r_e1;
          w_e1_next    = '0;
        end
      end
      default: begin
        w_state_next = VAZIO;
        w_e0_next    = '0;
        w_e1_next    = '0;
      end
    endcase
  end

  // State, buffer, registered ready and saturating overflow counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= VAZIO;
      r_e0     <= '0;
      r_e1     <= '0;
      r_pronto <= 1'b1;
      r_cont   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_e0     <= w_e0_next;
      r_e1     <= w_e1_next;
      r_pronto <= (w_state_next != CHEIO);
      if (w_accept && w_new.ovf && (r_cont != c_CNT_MAX))
        r_cont <= r_cont + 8'd1;
    end
  end

  assign bus.pronto_out       = r_pronto;
  assign bus.valido_out       = w_valido;
  assign bus.saida            = r_e0.saida;
  assign bus.byte_en          = r_e0.be;
  assign bus.overflow         = r_e0.ovf;
  assign bus.erro_alinhamento = r_e0.err;
  assign bus.cont_overflow    = r_cont;

endmodule
`default_nettype wire

// File: tb/tb_store_narrow.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_narrow
// Description : Directed self-checking bench for store_narrow.
// Revision    : 1.0  initial release
// ============================================================================
module tb_store_narrow;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  store_narrow_if u_if ();

  store_narrow u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  // Free-running clock, 10 time units per period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [31:0] d, input logic [1:0] e,
                         input logic [1:0] t, input logic c);
    u_if.dado     = d;
    u_if.endereco = e;
    u_if.tamanho  = t;
    u_if.controle = c;
  endtask

  // One-beat offer; result is visible right after the accepting edge
  task automatic send(input logic [31:0] d, input logic [1:0] e,
                      input logic [1:0] t, input logic c);
    set_req(d, e, t, c);
    u_if.valido_in = 1'b1;
    tick();
    u_if.valido_in = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    u_if.valido_in = 1'b0;
    u_if.pronto_in = 1'b1;
    set_req(32'h0, 2'd0, 2'b00, 1'b0);
    tick();
    tick();
    check("rst_valido_out", {31'h0, u_if.valido_out}, 32'h0);
    check("rst_pronto_out", {31'h0, u_if.pronto_out}, 32'h1);
    check("rst_saida", u_if.saida, 32'h0);
    check("rst_byte_en", {28'h0, u_if.byte_en}, 32'h0);
    check("rst_overflow", {31'h0, u_if.overflow}, 32'h0);
    check("rst_erro", {31'h0, u_if.erro_alinhamento}, 32'h0);
    check("rst_cont", {24'h0, u_if.cont_overflow}, 32'h0);
    reset = 1'b0;
    tick();

    // Byte to lane 2, signed, in range
    send(32'h0000000A, 2'd2, 2'b00, 1'b1);
    check("b_lane2_valid", {31'h0, u_if.valido_out}, 32'h1);
    check("b_lane2_saida", u_if.saida, 32'h000A0000);
    check("b_lane2_be", {28'h0, u_if.byte_en}, 32'h4);
    check("b_lane2_ovf", {31'h0, u_if.overflow}, 32'h0);

    // -128 as signed byte fits
    send(32'hFFFFFF80, 2'd0, 2'b00, 1'b1);
    check("b_s80_saida", u_if.saida, 32'h00000080);
    check("b_s80_ovf", {31'h0, u_if.overflow}, 32'h0);
    check("b_s80_cont", {24'h0, u_if.cont_overflow}, 32'h0);

    // Same value unsigned overflows
    send(32'hFFFFFF80, 2'd0, 2'b00, 1'b0);
    check("b_u80_ovf", {31'h0, u_if.overflow}, 32'h1);
    check("b_u80_cont", {24'h0, u_if.cont_overflow}, 32'h1);
`ifdef STORE_NARROW_SATURATE_EN
    check("b_u80_saida", u_if.saida, 32'h000000FF);
`else
    check("b_u80_saida", u_if.saida, 32'h00000080);
`endif

    // 0x100 unsigned byte
    send(32'h00000100, 2'd0, 2'b00, 1'b0);
    check("b_u100_ovf", {31'h0, u_if.overflow}, 32'h1);
`ifdef STORE_NARROW_SATURATE_EN
    check("b_u100_saida", u_if.saida, 32'h000000FF);
`else
    check("b_u100_saida", u_if.saida, 32'h00000000);
`endif
    check("b_u100_cont", {24'h0, u_if.cont_overflow}, 32'h2);

    // Misaligned half
    send(32'h00001234, 2'd1, 2'b01, 1'b0);
    check("h_mis_erro", {31'h0, u_if.erro_alinhamento}, 32'h1);
    check("h_mis_be", {28'h0, u_if.byte_en}, 32'h0);
    check("h_mis_saida", u_if.saida, 32'h0);
    check("h_mis_ovf", {31'h0, u_if.overflow}, 32'h0);

    // Reserved size
    send(32'h00000001, 2'd0, 2'b11, 1'b0);
    check("rsv_erro", {31'h0, u_if.erro_alinhamento}, 32'h1);
    check("rsv_be", {28'h0, u_if.byte_en}, 32'h0);

    // Misaligned word
    send(32'h00000001, 2'd2, 2'b10, 1'b0);
    check("w_mis_erro", {31'h0, u_if.erro_alinhamento}, 32'h1);

    // Signed half to upper lanes
    send(32'hFFFF8000, 2'd2, 2'b01, 1'b1);
    check("h_s_saida", u_if.saida, 32'h80000000);
    check("h_s_be", {28'h0, u_if.byte_en}, 32'hC);
    check("h_s_ovf", {31'h0, u_if.overflow}, 32'h0);
    check("h_s_erro", {31'h0, u_if.erro_alinhamento}, 32'h0);

    // Aligned word passes through
    send(32'hDEADBEEF, 2'd0, 2'b10, 1'b1);
    check("w_saida", u_if.saida, 32'hDEADBEEF);
    check("w_be", {28'h0, u_if.byte_en}, 32'hF);
    check("w_ovf", {31'h0, u_if.overflow}, 32'h0);

    // Unsigned half overflow
    send(32'h00012345, 2'd0, 2'b01, 1'b0);
    check("h_u_ovf", {31'h0, u_if.overflow}, 32'h1);
    check("h_u_be", {28'h0, u_if.byte_en}, 32'h3);
`ifdef STORE_NARROW_SATURATE_EN
    check("h_u_saida", u_if.saida, 32'h0000FFFF);
`else
    check("h_u_saida", u_if.saida, 32'h00002345);
`endif

    // Signed half positive overflow
    send(32'h00008000, 2'd0, 2'b01, 1'b1);
    check("h_sp_ovf", {31'h0, u_if.overflow}, 32'h1);
`ifdef STORE_NARROW_SATURATE_EN
    check("h_sp_saida", u_if.saida, 32'h00007FFF);
`else
    check("h_sp_saida", u_if.saida, 32'h00008000);
`endif
    check("h_sp_cont", {24'h0, u_if.cont_overflow}, 32'h4);

    // Drain
    tick();
    check("drain_valid", {31'h0, u_if.valido_out}, 32'h0);
    check("drain_pronto", {31'h0, u_if.pronto_out}, 32'h1);

    // Back-pressure: three back-to-back offers, downstream stalled
    u_if.pronto_in = 1'b0;
    u_if.valido_in = 1'b1;
    set_req(32'h00000001, 2'd0, 2'b00, 1'b1);
    tick();
    set_req(32'h00000002, 2'd1, 2'b00, 1'b1);
    tick();
    set_req(32'h00000003, 2'd3, 2'b00, 1'b1);
    tick();
    check("bp_pronto_full", {31'h0, u_if.pronto_out}, 32'h0);
    check("bp_valid", {31'h0, u_if.valido_out}, 32'h1);
    check("bp_head_a", u_if.saida, 32'h00000001);
    u_if.pronto_in = 1'b1;
    tick();
    check("bp_head_b", u_if.saida, 32'h00000200);
    check("bp_pronto_um", {31'h0, u_if.pronto_out}, 32'h1);
    tick();
    u_if.valido_in = 1'b0;
    check("bp_head_c", u_if.saida, 32'h03000000);
    check("bp_be_c", {28'h0, u_if.byte_en}, 32'h8);
    check("bp_c_valid", {31'h0, u_if.valido_out}, 32'h1);
    tick();
    check("bp_drained", {31'h0, u_if.valido_out}, 32'h0);

    // Fill with the counter at 5, then reset
    u_if.pronto_in = 1'b0;
    send(32'h000001FF, 2'd0, 2'b00, 1'b0);
    send(32'h00000005, 2'd0, 2'b00, 1'b1);
    check("full_cont", {24'h0, u_if.cont_overflow}, 32'h5);
    check("full_pronto", {31'h0, u_if.pronto_out}, 32'h0);
    reset          = 1'b1;
    u_if.pronto_in = 1'b1;
    u_if.valido_in = 1'b1;
    tick();
    check("rst2_valid", {31'h0, u_if.valido_out}, 32'h0);
    check("rst2_pronto", {31'h0, u_if.pronto_out}, 32'h1);
    check("rst2_cont", {24'h0, u_if.cont_overflow}, 32'h0);
    check("rst2_saida", u_if.saida, 32'h0);
    reset          = 1'b0;
    u_if.valido_in = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_narrow.md
STORE_NARROW -- requirements
Module: store_narrow

Interface
REQ-001 SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have port: clock  in  1  rising-edge clock.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: valido_in  in  1  upstream transaction valid.
REQ-005 SHALL have port: pronto_out  out  1  block can accept a transaction.
REQ-006 SHALL have port: dado  in  32  full-width store value.
REQ-007 SHALL have port: endereco  in  2  byte offset within the word.
REQ-008 SHALL have port: tamanho  in  2  size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port: controle  in  1  1 = signed range check, 0 = unsigned.
REQ-010 SHALL have port: valido_out  out  1  output transaction valid.
REQ-011 SHALL have port: pronto_in  in  1  downstream ready.
REQ-012 SHALL have port: saida  out  32  narrowed value placed on its byte lane(s).
REQ-013 SHALL have port: byte_en  out  4  byte write enables, bit i = byte lane i.
REQ-014 SHALL have port: overflow  out  1  value did not fit the selected size.
REQ-015 SHALL have port: erro_alinhamento  out  1  misaligned or reserved size.
REQ-016 SHALL have port: cont_overflow  out  8  saturating count of overflowing transactions.

Function
REQ-017 SHALL accept a transaction on a clock edge where valido_in and pronto_out are both 1.
REQ-018 SHALL hold up to two transactions in a FIFO-ordered skid buffer, with occupancy states VAZIO, UM and CHEIO.
REQ-019 SHALL drive pronto_out = 1 in VAZIO and UM, and 0 in CHEIO; pronto_out is a registered output.
REQ-020 SHALL present the oldest entry on saida, byte_en, overflow and erro_alinhamento while valido_out = 1; valido_out = 1 in UM and CHEIO.
REQ-021 SHALL consume the oldest entry on an edge where valido_out and pronto_in are both 1.
REQ-022 SHALL apply these occupancy transitions: accept without consume increments occupancy; consume without accept decrements it; simultaneous accept and consume in UM stays in UM with the new entry.
REQ-023 SHALL give a one-cycle latency: a transaction accepted in VAZIO appears on the outputs on the next cycle.
REQ-024 SHALL check byte range as follows: signed fits iff dado[31:7] are all equal; unsigned fits iff dado[31:8] = 0.
REQ-025 SHALL check half range as follows: signed fits iff dado[31:15] are all equal; unsigned fits iff dado[31:16] = 0.
REQ-026 SHALL treat a word as always fitting.
REQ-027 SHALL set overflow to 1 when the value does not fit.
REQ-028 SHALL place the narrowed value at bit 8*endereco, with all other saida bits 0.
REQ-029 SHALL set byte_en to 0001<<endereco for a byte, 0011<<endereco for a half, and 1111 for a word.
REQ-030 SHALL flag as misaligned: a half with endereco[0] = 1, a word with endereco != 0, and tamanho = 11.
REQ-031 SHALL, for a misaligned transaction, set erro_alinhamento = 1, byte_en = 0000, saida = 0 and overflow = 0.
REQ-032 SHALL increment cont_overflow on acceptance of a transaction with overflow = 1, and hold it at 255 once reached (saturate).

Reset
REQ-033 SHALL, on reset, force VAZIO and drive pronto_out = 1, valido_out = 0, saida = 0, byte_en = 0, overflow = 0, erro_alinhamento = 0 and cont_overflow = 0.
REQ-034 SHALL have reset take priority over simultaneous accept and consume; buffered entries are discarded.

Configuration
REQ-035 SHALL, when STORE_NARROW_SATURATE_EN is defined, clamp out-of-range values to the limit of the selected size: signed byte 0x7F/0x80, signed half 0x7FFF/0x8000, unsigned byte 0xFF, unsigned half 0xFFFF.
REQ-036 SHALL, when STORE_NARROW_SATURATE_EN is not defined, truncate out-of-range values to their low 8 or 16 bits.
REQ-037 SHALL raise overflow in both configurations.

Verification
REQ-038 SHALL cover: dado=0x0000000A, tamanho=00, controle=1, endereco=2, pronto_in=1 -> next cycle saida=0x000A0000, byte_en=0100, overflow=0.
REQ-039 SHALL cover: dado=0xFFFFFF80, byte, signed, endereco=0 -> saida=0x00000080, overflow=0; the same input unsigned -> overflow=1 and cont_overflow=1.
REQ-040 SHALL cover: dado=0x00000100, byte, unsigned -> overflow=1, with saida=0x00000000 without the macro and 0x000000FF with it.
REQ-041 SHALL cover: half with endereco=1 -> erro_alinhamento=1, byte_en=0000, saida=0; and tamanho=11 -> erro_alinhamento=1.
REQ-042 SHALL cover: pronto_in=0 while three back-to-back valid inputs are offered -> two accepted and pronto_out=0; then pronto_in=1 -> both emerge in order and the third is accepted.
REQ-043 SHALL cover: reset asserted while CHEIO with cont_overflow=5 -> next cycle valido_out=0, pronto_out=1, cont_overflow=0.
